// File: rtl/clint_pkg.sv
// Shared CLINT configuration: bus widths, window base, register offsets, size encodings
// and the small decode helpers used by the bus front end and the timer.
package clint_pkg;

  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned SIZE_WIDTH     = 2;
  localparam int unsigned REG_DATA_WIDTH = 32;
  localparam int unsigned BUS_DATA_WIDTH = 32;

  // Base of the CLINT window; the bus strips it before offsets reach the block.
  localparam logic [ADDR_WIDTH-1:0] CLINT_ADDR = 32'h0200_0000;

  // Register byte offsets inside the window.
  localparam logic [15:0] OFF_MSIP        = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] OFF_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] OFF_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] OFF_MTIME_HI    = 16'hBFFC;

  // Access size encodings; 2'b11 is reserved and treated as an illegal access.
  localparam logic [SIZE_WIDTH-1:0] SIZE_BYTE = 2'b00;
  localparam logic [SIZE_WIDTH-1:0] SIZE_HALF = 2'b01;
  localparam logic [SIZE_WIDTH-1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    RegNone,
    RegMsip,
    RegCmpLo,
    RegCmpHi,
    RegTimeLo,
    RegTimeHi
  } reg_sel_e;

  // Map a window offset to the 32-bit register it addresses.
  function automatic reg_sel_e decode_reg(input logic [ADDR_WIDTH-1:0] addr);
    reg_sel_e sel;
    sel = RegNone;
    if (addr[ADDR_WIDTH-1:16] == '0) begin
      case (addr[15:2])
        OFF_MSIP[15:2]:        sel = RegMsip;
        OFF_MTIMECMP_LO[15:2]: sel = RegCmpLo;
        OFF_MTIMECMP_HI[15:2]: sel = RegCmpHi;
        OFF_MTIME_LO[15:2]:    sel = RegTimeLo;
        OFF_MTIME_HI[15:2]:    sel = RegTimeHi;
        default:               sel = RegNone;
      endcase
    end
    return sel;
  endfunction

  // Byte-lane enables for an access; all-zero for misaligned or reserved-size accesses.
  function automatic logic [3:0] lane_mask(input logic [SIZE_WIDTH-1:0] size,
                                           input logic [1:0]            lane);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      SIZE_BYTE: mask = 4'b0001 << lane;
      SIZE_HALF: mask = lane[0] ? 4'b0000 : (4'b0011 << lane);
      SIZE_WORD: mask = (lane == 2'b00) ? 4'b1111 : 4'b0000;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Replace the enabled bytes of old_word with the matching bytes of new_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[i*8 +: 8] = new_word[i*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// CLINT timer core: prescaler, 64-bit mtime, 64-bit mtimecmp and the registered mtip compare.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned MTIME_DIV = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_mtime_lo_be,
  input  logic [3:0]  i_mtime_hi_be,
  input  logic [3:0]  i_cmp_lo_be,
  input  logic [3:0]  i_cmp_hi_be,
  output logic [63:0] o_mtime,
  output logic [63:0] o_mtimecmp,
  output logic        o_mtip
);

  localparam int unsigned PRESC_W = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(MTIME_DIV - 1);

  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] w_presc_d;
  logic               w_presc_wrap;
  logic [63:0]        r_mtime;
  logic [63:0]        w_mtime_d;
  logic               w_mtime_wr;
  logic [63:0]        r_mtimecmp;
  logic [63:0]        w_mtimecmp_d;
  logic               r_mtip;

  // Prescaler wrap and mtime/mtimecmp next state; a bus write to mtime suppresses that
  // cycle's increment so untouched lanes keep their pre-increment value.
  always_comb begin
    w_presc_wrap = (r_presc == PRESC_MAX);
    w_presc_d    = w_presc_wrap ? '0 : r_presc + 1'b1;
    w_mtime_wr   = |{i_mtime_lo_be, i_mtime_hi_be};
    if (w_mtime_wr) begin
      w_mtime_d = {merge_bytes(r_mtime[63:32], i_wdata, i_mtime_hi_be),
                   merge_bytes(r_mtime[31:0],  i_wdata, i_mtime_lo_be)};
    end else if (w_presc_wrap) begin
      w_mtime_d = r_mtime + 64'd1;
    end else begin
      w_mtime_d = r_mtime;
    end
    w_mtimecmp_d = {merge_bytes(r_mtimecmp[63:32], i_wdata, i_cmp_hi_be),
                    merge_bytes(r_mtimecmp[31:0],  i_wdata, i_cmp_lo_be)};
  end

  // Timer state; mtimecmp resets to all ones so no interrupt fires out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc    <= '0;
      r_mtime    <= '0;
      r_mtimecmp <= '1;
    end else begin
      r_presc    <= w_presc_d;
      r_mtime    <= w_mtime_d;
      r_mtimecmp <= w_mtimecmp_d;
    end
  end

  // mtip registers the compare of the current (pre-edge) register values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mtip <= 1'b0;
    end else begin
      r_mtip <= (r_mtime >= r_mtimecmp);
    end
  end

  assign o_mtime    = r_mtime;
  assign o_mtimecmp = r_mtimecmp;
  assign o_mtip     = r_mtip;

endmodule

// File: rtl/clint.sv
// CLINT top: bus decode, byte-lane handling, registered read mux and the msip bit.
module clint
  import clint_pkg::*;
#(
  parameter int unsigned MTIME_DIV = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     bus_clint_read_addr,
  input  logic [ADDR_WIDTH-1:0]     bus_clint_write_addr,
  input  logic [SIZE_WIDTH-1:0]     bus_clint_read_size,
  input  logic [SIZE_WIDTH-1:0]     bus_clint_write_size,
  input  logic [REG_DATA_WIDTH-1:0] bus_clint_data,
  input  logic                      bus_clint_rd,
  input  logic                      bus_clint_wr,
  output logic [BUS_DATA_WIDTH-1:0] clint_bus_data,
  output logic                      clint_csr_msip,
  output logic                      clint_csr_mtip
);

  reg_sel_e                  w_rd_sel;
  reg_sel_e                  w_wr_sel;
  logic [3:0]                w_rd_be;
  logic [3:0]                w_rd_bytes;
  logic [31:0]               w_rd_word;
  logic [31:0]               w_rd_keep;
  logic [31:0]               w_rd_data;
  logic [3:0]                w_wr_be;
  logic [31:0]               w_wr_data;
  logic [3:0]                w_be_msip;
  logic [3:0]                w_be_cmp_lo;
  logic [3:0]                w_be_cmp_hi;
  logic [3:0]                w_be_time_lo;
  logic [3:0]                w_be_time_hi;
  logic [63:0]               w_mtime;
  logic [63:0]               w_mtimecmp;
  logic                      w_mtip;
  logic                      r_msip;
  logic [BUS_DATA_WIDTH-1:0] r_rdata;

  assign w_rd_sel = decode_reg(bus_clint_read_addr);
  assign w_rd_be  = lane_mask(bus_clint_read_size, bus_clint_read_addr[1:0]);
  assign w_wr_sel = decode_reg(bus_clint_write_addr);

  // Read mux: pick the word, shift the addressed lane down and keep only the accessed bytes.
  // An illegal access has no lane enables, so it reads as zero.
  always_comb begin
    w_rd_word = '0;
    case (w_rd_sel)
      RegMsip:   w_rd_word = {31'd0, r_msip};
      RegCmpLo:  w_rd_word = w_mtimecmp[31:0];
      RegCmpHi:  w_rd_word = w_mtimecmp[63:32];
      RegTimeLo: w_rd_word = w_mtime[31:0];
      RegTimeHi: w_rd_word = w_mtime[63:32];
      default:   w_rd_word = '0;
    endcase
    w_rd_bytes = w_rd_be >> bus_clint_read_addr[1:0];
    w_rd_keep  = '0;
    for (int i = 0; i < 4; i++) begin
      w_rd_keep[i*8 +: 8] = {8{w_rd_bytes[i]}};
    end
    w_rd_data = (w_rd_word >> {bus_clint_read_addr[1:0], 3'b000}) & w_rd_keep;
  end

  // Write decode: lane-align the right-justified data and steer byte enables to one register.
  always_comb begin
    w_wr_be      = bus_clint_wr ? lane_mask(bus_clint_write_size, bus_clint_write_addr[1:0])
                                : 4'b0000;
    w_wr_data    = 32'(bus_clint_data) << {bus_clint_write_addr[1:0], 3'b000};
    w_be_msip    = 4'b0000;
    w_be_cmp_lo  = 4'b0000;
    w_be_cmp_hi  = 4'b0000;
    w_be_time_lo = 4'b0000;
    w_be_time_hi = 4'b0000;
    case (w_wr_sel)
      RegMsip:   w_be_msip    = w_wr_be;
      RegCmpLo:  w_be_cmp_lo  = w_wr_be;
      RegCmpHi:  w_be_cmp_hi  = w_wr_be;
      RegTimeLo: w_be_time_lo = w_wr_be;
      RegTimeHi: w_be_time_hi = w_wr_be;
      default:   ;
    endcase
  end

  // msip is only bit 0 of its word; writes to the upper lanes are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_msip <= 1'b0;
    end else if (w_be_msip[0]) begin
      r_msip <= w_wr_data[0];
    end
  end

  // Read data is captured on the rd edge and held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (bus_clint_rd) begin
      r_rdata <= BUS_DATA_WIDTH'(w_rd_data);
    end
  end

  clint_timer #(
    .MTIME_DIV (MTIME_DIV)
  ) u_timer (
    .i_clk         (clk),
    .i_rst_n       (rst),
    .i_wdata       (w_wr_data),
    .i_mtime_lo_be (w_be_time_lo),
    .i_mtime_hi_be (w_be_time_hi),
    .i_cmp_lo_be   (w_be_cmp_lo),
    .i_cmp_hi_be   (w_be_cmp_hi),
    .o_mtime       (w_mtime),
    .o_mtimecmp    (w_mtimecmp),
    .o_mtip        (w_mtip)
  );

  assign clint_bus_data = r_rdata;
  assign clint_csr_msip = r_msip;
  assign clint_csr_mtip = w_mtip;

endmodule

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 SHALL have parameter MTIME_DIV, default 1, meaning clk cycles per mtime increment (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port bus_clint_read_addr  input  `ADDR_WIDTH  read byte offset within CLINT window; bus has already stripped the base.
REQ-005 SHALL have port bus_clint_write_addr  input  `ADDR_WIDTH  write byte offset within CLINT window.
REQ-006 SHALL have port bus_clint_read_size  input  `SIZE_WIDTH  access size: 00 byte, 01 half, 10 word.
REQ-007 SHALL have port bus_clint_write_size  input  `SIZE_WIDTH  access size, same encoding as read size.
REQ-008 SHALL have port bus_clint_data  input  `REG_DATA_WIDTH  write data, right-aligned.
REQ-009 SHALL have port bus_clint_rd  input  1  read strobe.
REQ-010 SHALL have port bus_clint_wr  input  1  write strobe.
REQ-011 SHALL have port clint_bus_data  output  `BUS_DATA_WIDTH  read data.
REQ-012 SHALL have port clint_csr_msip  output  1  machine software interrupt pending.
REQ-013 SHALL have port clint_csr_mtip  output  1  machine timer interrupt pending.

Function
REQ-014 SHALL map registers at offsets: msip 0x0000 (bit0 only; other bits read 0); mtimecmp 0x4000 (low) and 0x4004 (high); mtime 0xBFF8 (low) and 0xBFFC (high).
REQ-015 SHALL decode on addr[15:2] with addr[1:0] as byte lane; offsets above 0xFFFF SHALL be unmapped.
REQ-016 SHALL return read data registered, one cycle after bus_clint_rd=1: word>>(addr[1:0]*8), masked to size, zero-extended to `BUS_DATA_WIDTH.
REQ-017 SHALL hold clint_bus_data at its last value in cycles where bus_clint_rd=0.
REQ-018 SHALL perform writes on the edge where bus_clint_wr=1, updating only the byte lanes selected by size and addr[1:0].
REQ-019 SHALL ignore misaligned accesses: half with addr[0]=1, or word with addr[1:0]!=0. Such a read SHALL return 0; such a write SHALL change nothing.
REQ-020 SHALL return 0 for unmapped reads and SHALL ignore unmapped writes.
REQ-021 SHALL implement a prescaler: a counter of clk cycles that wraps at MTIME_DIV-1, with mtime (64-bit) incrementing on each wrap.
REQ-022 With MTIME_DIV=1, mtime SHALL increment every cycle.
REQ-023 mtime SHALL wrap from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-024 On a write to mtime in the same cycle as an increment, the written lanes SHALL take the write data and the other half SHALL keep its pre-increment value (write wins, no increment that cycle).
REQ-025 A read and a write to the same register in the same cycle SHALL return the pre-write value.
REQ-026 clint_csr_mtip SHALL be registered: (mtime >= mtimecmp), unsigned 64-bit compare, taken from the register values before the edge; mtip therefore lags a change by one cycle.
REQ-027 clint_csr_msip SHALL equal the msip register bit0 directly.

Reset
REQ-028 On rst=0 the block SHALL asynchronously set: mtime=0, prescaler=0, mtimecmp=all ones, msip=0, clint_bus_data=0, clint_csr_mtip=0.
REQ-029 A read or write in flight when reset asserts SHALL be discarded.
REQ-030 Counting SHALL resume on the first edge after rst deasserts.

Structure
REQ-031 CLINT register offsets and size encodings SHALL live in the shared config header beside `CLINT_ADDR and `SIZE_WIDTH.
REQ-032 The block SHALL instantiate one sub-module, clint_timer, holding the prescaler, mtime, mtimecmp and the mtip compare register.
REQ-033 Bus decode and read mux SHALL stay in clint.

Verification
REQ-034 Reset release, idle 10 cycles, read 0xBFF8 word -> data 0x0000000A (±1 per fixed sampling point); mtip=0.
REQ-035 Write word 0x1 to 0x0000 -> msip=1 the next cycle; read 0x0000 size 01 -> 0x1; write 0 -> msip=0.
REQ-036 Write mtimecmp high=0, low=0x20 -> mtip=1 on the cycle after mtime reaches 0x20; rewrite low=0xFFFFFFFF -> mtip=0 one cycle later.
REQ-037 Write mtime low=0xFFFFFFFF and high=0 -> after 1 cycle, high reads 0x1 and low reads 0x0 (carry).
REQ-038 With MTIME_DIV=4, 16 cycles -> mtime advances by 4.
REQ-039 Byte write 0xAB to 0x4001 -> mtimecmp low=0xFFFFABFF.
REQ-040 Misaligned word read at 0x4002 -> data 0.
REQ-041 Read of unmapped 0x8000 -> data 0.
